// File: rtl/neuron_step_controller.sv
// neuron_step_controller
//   Sequences a fixed number of explicit-Euler steps through an external
//   neuron datapath. The controller drives the current state y_t and waits
//   LATENCY cycles for the datapath to return y_t_next. It then publishes
//   that value on y_out with a valid/ready handshake, and repeats the
//   sequence until num_steps results have been accepted.
//
//   Parameters
//     LATENCY  datapath latency in clk cycles (1..255)
//     STEP_W   width of num_steps / step_count
//
//   Ports
//     clk, rst        single clock, synchronous active-high reset
//     start           run request, sampled only in IDLE
//     num_steps       steps to run, latched on an accepted start
//     y_init          initial state (fp32), latched on an accepted start
//     y_t_next        updated state from the datapath
//     y_t             registered current state to the datapath
//     out_valid/out_ready/y_out   per-step result handshake
//     step_count      results accepted so far in this run
//     busy            high outside IDLE
//     done            one-cycle end-of-run pulse
//     error           sticky NaN/Inf trap flag
//
//   Optional feature: define NEURON_NAN_TRAP_EN to abort a run when the
//   datapath returns a NaN or Inf (all-ones exponent). When the macro is
//   undefined, error is tied to 0 and such values pass through unchanged.
module neuron_step_controller #(
    parameter int LATENCY = 8,
    parameter int STEP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [31:0]       y_init,
    input  logic [31:0]       y_t_next,
    output logic [31:0]       y_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       y_out,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [31:0]       y_t_q, y_t_d;
    logic [31:0]       y_out_q, y_out_d;
    logic              out_valid_q, out_valid_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;
    logic [STEP_W-1:0] num_steps_q, num_steps_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              trap;

`ifdef NEURON_NAN_TRAP_EN
    assign trap = (y_t_next[30:23] == 8'hFF);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        y_t_d        = y_t_q;
        y_out_d      = y_out_q;
        out_valid_d  = out_valid_q;
        step_count_d = step_count_q;
        num_steps_d  = num_steps_q;
        wait_cnt_d   = wait_cnt_q;
        done_d       = 1'b0;
        error_d      = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_steps == '0) begin
                        // Empty run: acknowledge with done and keep all state.
                        done_d = 1'b1;
                    end else begin
                        y_t_d        = y_init;
                        num_steps_d  = num_steps;
                        step_count_d = '0;
                        wait_cnt_d   = '0;
                        error_d      = 1'b0;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    if (trap) begin
                        // Poisoned result: keep the last good y_t and end the run.
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        y_t_d       = y_t_next;
                        y_out_d     = y_t_next;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    step_count_d = step_count_q + 1'b1;
                    out_valid_d  = 1'b0;
                    if (step_count_d == num_steps_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            y_t_q        <= '0;
            y_out_q      <= '0;
            out_valid_q  <= 1'b0;
            step_count_q <= '0;
            num_steps_q  <= '0;
            wait_cnt_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_t_q        <= y_t_d;
            y_out_q      <= y_out_d;
            out_valid_q  <= out_valid_d;
            step_count_q <= step_count_d;
            num_steps_q  <= num_steps_d;
            wait_cnt_q   <= wait_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign y_t        = y_t_q;
    assign y_out      = y_out_q;
    assign out_valid  = out_valid_q;
    assign step_count = step_count_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_neuron_step_controller.sv
module tb_neuron_step_controller;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [15:0] num_steps;
    logic [31:0] y_init, y_t_next, y_t, y_out;
    logic        out_valid, busy, done, error;
    logic [15:0] step_count;
    logic        nan_mode;
    int          total = 0;
    int          fails = 0;
    int          n;
    logic        saw_valid;

    neuron_step_controller #(.LATENCY(8), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .y_init(y_init), .y_t_next(y_t_next), .y_t(y_t),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .step_count(step_count), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Datapath model: y_t + 0.5 for the values this bench visits.
    always_comb begin
        case (y_t)
            32'h3F800000: y_t_next = 32'h3FC00000;
            32'h3FC00000: y_t_next = 32'h40000000;
            32'h40000000: y_t_next = 32'h40200000;
            32'h40200000: y_t_next = 32'h40400000;
            32'h40400000: y_t_next = 32'h40600000;
            default:      y_t_next = y_t;
        endcase
        if (nan_mode) y_t_next = 32'h7FC00000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until out_valid rises, bounded; returns ticks taken.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1; start = 0; out_ready = 0; num_steps = 0; y_init = 0; nan_mode = 0;
        tick(); tick();
        rst = 0;
        chk("rst_y_t", y_t, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_flags", {out_valid, busy, done, error}, 4'b0000);
        chk("rst_step_count", step_count, 0);

        // Run A: 3 steps, with a 5-cycle stall on the first result.
        num_steps = 3; y_init = 32'h3F800000; start = 1;
        tick();
        start = 0; num_steps = 7; y_init = 32'h12345678; // must be ignored while busy
        chk("a_busy", busy, 1);
        chk("a_y_t_init", y_t, 32'h3F800000);
        repeat (7) tick();
        chk("a_lat_early", out_valid, 0);
        tick();
        chk("a_lat_valid", out_valid, 1);
        chk("a_y_out1", y_out, 32'h3FC00000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_stall_valid", out_valid, 1);
            chk("a_stall_y_out", y_out, 32'h3FC00000);
            chk("a_stall_y_t", y_t, 32'h3FC00000);
            chk("a_stall_cnt", step_count, 0);
        end
        out_ready = 1;
        tick();
        chk("a_hs1_valid", out_valid, 0);
        chk("a_hs1_cnt", step_count, 1);
        wait_valid(n);
        chk("a_wait2", n, 8);
        chk("a_y_out2", y_out, 32'h40000000);
        tick();
        chk("a_hs2_cnt", step_count, 2);
        chk("a_hs2_done", done, 0);
        wait_valid(n);
        chk("a_wait3", n, 8);
        chk("a_y_out3", y_out, 32'h40200000);
        tick();
        chk("a_end_flags", {out_valid, busy, done}, 3'b001);
        chk("a_end_cnt", step_count, 3);
        tick();
        chk("a_done_pulse", done, 0);

        // num_steps = 0: lone done pulse, no state change.
        num_steps = 0; start = 1;
        tick();
        start = 0;
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_y_t", y_t, 32'h40200000);
        tick();
        chk("z_done_off", done, 0);

        // Reset during WAIT of step 2.
        num_steps = 3; y_init = 32'h3F800000; start = 1;
        tick();
        start = 0;
        wait_valid(n);
        chk("r_wait1", n, 8);
        tick();
        repeat (3) tick();
        chk("r_in_wait", {busy, out_valid}, 2'b10);
        rst = 1;
        tick();
        rst = 0;
        chk("r_y_t", y_t, 0);
        chk("r_y_out", y_out, 0);
        chk("r_flags", {out_valid, busy, done, error}, 4'b0000);
        chk("r_cnt", step_count, 0);
        tick();
        chk("r_no_done", {busy, done}, 2'b00);
        num_steps = 1; start = 1;
        tick();
        start = 0;
        wait_valid(n);
        chk("r_restart_wait", n, 8);
        chk("r_restart_y_out", y_out, 32'h3FC00000);
        tick();
        chk("r_restart_done", done, 1);
        chk("r_restart_cnt", step_count, 1);

        // Datapath returns NaN on step 2.
        num_steps = 3; y_init = 32'h3F800000; start = 1;
        tick();
        start = 0;
        wait_valid(n);
        chk("n_y_out1", y_out, 32'h3FC00000);
        nan_mode = 1;
        tick();
`ifdef NEURON_NAN_TRAP_EN
        saw_valid = 0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (out_valid) saw_valid = 1;
        end
        chk("n_done", done, 1);
        chk("n_trap_time", n, 8);
        chk("n_no_valid", saw_valid, 0);
        chk("n_error", error, 1);
        chk("n_y_t", y_t, 32'h3FC00000);
        chk("n_busy", busy, 0);
        nan_mode = 0;
        tick();
        chk("n_error_sticky", error, 1);
`else
        wait_valid(n);
        chk("n_pass_wait", n, 8);
        chk("n_pass_y_out", y_out, 32'h7FC00000);
        chk("n_pass_error", error, 0);
        nan_mode = 0;
        rst = 1;
        tick();
        rst = 0;
`endif

        // start held through a 4-step run while num_steps changes to 2.
        num_steps = 4; y_init = 32'h3F800000; start = 1;
        tick();
        num_steps = 2;
        chk("h_error_clr", error, 0);
        for (int s = 1; s <= 4; s++) begin
            wait_valid(n);
            chk("h_wait", n, 8);
            chk("h_busy", busy, 1);
            tick();
            chk("h_cnt", step_count, s);
        end
        chk("h_done1", {busy, done}, 2'b01);
        tick();
        start = 0;
        chk("h_rerun_busy", busy, 1);
        chk("h_rerun_cnt", step_count, 0);
        for (int s = 1; s <= 2; s++) begin
            wait_valid(n);
            chk("h2_wait", n, 8);
            tick();
        end
        chk("h_done2", {busy, done}, 2'b01);
        chk("h_cnt2", step_count, 2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
